sa_psum_collector: RTL and testbench
====================================

// Module: sa_psum_collector
// PURPOSE
//  Consumes 12-bit partial sums leaving the bottom row of PEs (out_bot of each column).
//  Removes the systolic column skew and extends sums to ACC_W.
//  Accumulates across K-tiles in a row buffer; final-tile rows go to an output FIFO (valid/ready).
//  Sits directly downstream of the PE array, upstream of writeback.
// PARAMETERS
//  COLS        4   PE array columns; column j emerges j cycles after column 0
//  PSUM_W      12  PE partial-sum width (out_bot)
//  ACC_W       16  accumulator / output element width, >= PSUM_W
//  DEPTH       8   result rows per tile held in accumulation buffer
//  FIFO_DEPTH  4   output FIFO entries (rows)
// PORTS
//  clk           in   1             clock, rising edge
//  reset         in   1             synchronous, active-high
//  col_psum      in   COLS*PSUM_W   column j at [j*PSUM_W +: PSUM_W], skewed
//  col0_valid    in   1             column 0 of col_psum carries a result row this cycle
//  is_signed     in   1             sign-extend (1) / zero-extend (0), sampled at tile_start
//  tile_start    in   1             pulse: begin tile; tile_first/tile_last sampled with it
//  tile_first    in   1             tile overwrites buffer (no add)
//  tile_last     in   1             tile's accumulated rows are pushed to output FIFO
//  tile_end      in   1             pulse: no further col0_valid for this tile
//  out_data      out  COLS*ACC_W    output row, column j at [j*ACC_W +: ACC_W]
//  out_valid     out  1             FIFO non-empty
//  out_ready     in   1             consumer accepts out_data when out_valid&out_ready
//  busy          out  1             state != IDLE
//  tile_done     out  1             1-cycle pulse on DRAIN->IDLE
//  overflow_err  out  1             sticky: FIFO push while full, or row index >= DEPTH
//  protocol_err  out  1             sticky: tile_start while busy
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, row counter 0, state IDLE; buffer contents undefined.
//  Reset mid-operation aborts the tile. No output; busy=0 on the cycle after reset.
//  FSM IDLE -tile_start-> RUN -tile_end-> DRAIN -(COLS+1 cycles)-> IDLE with tile_done.
//  Mode flags latch on the accepted tile_start.
//  tile_start outside IDLE is ignored and sets protocol_err.
//  col0_valid outside RUN/DRAIN is ignored.
//  Deskew: column j delayed COLS-1-j registers; col0_valid delayed COLS-1 registers.
//  Aligned row appears at cycle t+COLS-1 for col0_valid at t.
//  Extend: per is_signed to ACC_W. Sum = extended + buf[row] (or extended if tile_first).
//  Sum wraps mod 2^ACC_W; no saturation.
//  Accumulate stage registers at t+COLS; row counter increments per aligned row.
//  Row counter clears at tile_start.
//  Row index >= DEPTH: row dropped, overflow_err set.
//  tile_last=0: sum written to buf[row]. tile_last=1: sum pushed to FIFO; buf not written.
//  FIFO is registered, not fall-through: earliest out_valid at t+COLS+1. Rows leave in arrival order.
//  Full FIFO with out_ready=1 same cycle: pop and push both succeed.
//  Full FIFO with out_ready=0: push dropped, overflow_err set.
//  out_data is held stable while out_valid & !out_ready.
//  The array cannot stall, so there is no backpressure upstream.
// STRUCTURE
//  sa_pkg: PSUM_W, ACT_W=4 constants; collector_state_t enum {IDLE,RUN,DRAIN}; sign-extend function.
//  Sub-module sa_sync_fifo (WIDTH, DEPTH; push/pop/full/empty) for the output FIFO.
//  Deskew, accumulate and FSM are inline.
// TESTING (COLS=4, ACC_W=16, DEPTH=8, FIFO_DEPTH=4)
//  1 Single tile, first=last=1, unsigned, column j = j+1 skewed from t
//    -> out_data {4,3,2,1} (col3..0), out_valid at t+5, tile_done after DRAIN.
//  2 psum 12'hFFF in all columns: is_signed=1 -> 16'hFFFF; is_signed=0 -> 16'h0FFF.
//  3 Tile A first=1,last=0 all 12'd100; tile B first=0,last=1 all 12'd23
//    -> every column 16'd123; no output during A.
//  4 out_ready=0, last tile of 5 rows (values 1..5)
//    -> FIFO holds 1..4, overflow_err=1; release ready -> 1,2,3,4 in order.
//  5 tile_start during RUN -> protocol_err=1; current tile results unchanged.
//  6 reset asserted in DRAIN -> next cycle busy=0, out_valid=0, errors 0.
//    A following clean tile behaves as test 1.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared constants, collector state encoding and the partial-sum extension helper.
package sa_pkg;

  localparam int ACT_W  = 4;
  // A 4b x 4b product is 8 bits; summing 16 PE rows adds 4 bits of growth.
  localparam int PSUM_W = 2 * ACT_W + 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } collector_state_t;

  function automatic logic [31:0] extend_psum(input logic [31:0] v, input int w, input logic sgn);
    logic [31:0] mask;
    logic        msb;
    mask = (32'd1 << w) - 32'd1;
    msb  = |(v & (32'd1 << (w - 1)));
    extend_psum = (sgn && msb) ? (v | ~mask) : (v & mask);
  endfunction

endpackage

// File: rtl/sa_sync_fifo.sv
// Registered synchronous FIFO; a push into a full FIFO succeeds only when a pop happens in the same cycle.
module sa_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
      if (do_pop)  rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/sa_psum_collector.sv
// Deskews PE-array column outputs, accumulates rows across K-tiles and queues final rows for writeback.
module sa_psum_collector
  import sa_pkg::*;
#(
  parameter int COLS       = 4,
  parameter int PSUM_W     = sa_pkg::PSUM_W,
  parameter int ACC_W      = 16,
  parameter int DEPTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COLS*PSUM_W-1:0] col_psum,
  input  logic                   col0_valid,
  input  logic                   is_signed,
  input  logic                   tile_start,
  input  logic                   tile_first,
  input  logic                   tile_last,
  input  logic                   tile_end,
  output logic [COLS*ACC_W-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   tile_done,
  output logic                   overflow_err,
  output logic                   protocol_err,
  output collector_state_t       dbg_state
);

  localparam int RW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(COLS + 1);

  collector_state_t state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             done_q, done_d;
  logic             start_ok, in_valid, aligned_valid, row_ok;
  logic             sgn_q, first_q, last_q, ovf_q, prot_q;
  logic [RW-1:0]    row_q;
  logic [RW-2:0]    row_idx;
  logic [COLS-1:1]  vld_q;

  logic [COLS-1:0][PSUM_W-1:0] aligned;
  logic [COLS-1:0][ACC_W-1:0]  sum, buf_rd;
  logic [COLS*ACC_W-1:0]       buf_q [DEPTH];
  logic [COLS*ACC_W-1:0]       acc_q, fifo_dout;
  logic                        acc_vld_q, fifo_full, fifo_empty, fifo_drop;
  logic [31:0]                 ext;

  assign start_ok = tile_start && (state_q == IDLE);
  assign in_valid = col0_valid && ((state_q == RUN) || (state_q == DRAIN));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  // DRAIN holds for COLS+1 cycles so the last row clears deskew and accumulate.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (tile_start) state_d = RUN;
      RUN: begin
        if (tile_end) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (drain_q == DW'(COLS)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) vld_q <= '0;
    else begin
      vld_q[1] <= in_valid;
      for (int k = 2; k < COLS; k++) vld_q[k] <= vld_q[k-1];
    end
  end
  assign aligned_valid = vld_q[COLS-1];

  for (genvar j = 0; j < COLS; j++) begin : g_deskew
    localparam int D = COLS - 1 - j;
    if (D == 0) begin : g_pass
      assign aligned[j] = col_psum[j*PSUM_W +: PSUM_W];
    end else begin : g_dly
      logic [PSUM_W-1:0] pipe_q [1:D];
      always_ff @(posedge clk) begin
        pipe_q[1] <= col_psum[j*PSUM_W +: PSUM_W];
        for (int k = 2; k <= D; k++) pipe_q[k] <= pipe_q[k-1];
      end
      assign aligned[j] = pipe_q[D];
    end
  end

  assign row_ok  = (row_q < RW'(DEPTH));
  assign row_idx = row_q[RW-2:0];
  assign buf_rd  = buf_q[row_idx];

  always_comb begin
    ext = '0;
    sum = '0;
    for (int j = 0; j < COLS; j++) begin
      ext    = extend_psum(32'(aligned[j]), PSUM_W, sgn_q);
      sum[j] = ACC_W'(ext) + (first_q ? '0 : buf_rd[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sgn_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      row_q     <= '0;
      acc_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      prot_q    <= 1'b0;
    end else begin
      acc_vld_q <= 1'b0;
      if (start_ok) begin
        sgn_q   <= is_signed;
        first_q <= tile_first;
        last_q  <= tile_last;
        row_q   <= '0;
      end else if (aligned_valid) begin
        if (row_ok) begin
          row_q <= row_q + RW'(1);
          if (last_q) begin
            acc_q     <= sum;
            acc_vld_q <= 1'b1;
          end
        end else begin
          ovf_q <= 1'b1;
        end
      end
      if (fifo_drop) ovf_q <= 1'b1;
      if (tile_start && (state_q != IDLE)) prot_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (aligned_valid && row_ok && !last_q) buf_q[row_idx] <= sum;
  end

  // Output handshake: a row transfers on any cycle with out_valid && out_ready;
  // out_data stays stable while out_valid is high and out_ready is low.
  assign fifo_drop = acc_vld_q && fifo_full && !out_ready;

  sa_sync_fifo #(
    .WIDTH(COLS * ACC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (acc_vld_q),
    .push_data_i(acc_q),
    .pop_i      (out_ready),
    .pop_data_o (fifo_dout),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign out_valid    = !fifo_empty;
  assign out_data     = out_valid ? fifo_dout : '0;
  assign busy         = (state_q != IDLE);
  assign tile_done    = done_q;
  assign overflow_err = ovf_q;
  assign protocol_err = prot_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sa_psum_collector.sv
// Randomized bench for sa_psum_collector: integer reference model feeds a scoreboard queue drained by a monitor.
module tb_sa_psum_collector;

  localparam int COLS       = 4;
  localparam int PSUM_W     = 12;
  localparam int ACC_W      = 16;
  localparam int DEPTH      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int MAXR       = 12;
  localparam int W          = COLS * ACC_W;

  logic                   clk, reset;
  logic [COLS*PSUM_W-1:0] col_psum;
  logic                   col0_valid, is_signed, tile_start, tile_first, tile_last, tile_end;
  logic [W-1:0]           out_data;
  logic                   out_valid, out_ready, busy, tile_done, overflow_err, protocol_err;
  sa_pkg::collector_state_t dbg_state;

  sa_psum_collector #(
    .COLS(COLS), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .col_psum(col_psum), .col0_valid(col0_valid),
    .is_signed(is_signed), .tile_start(tile_start), .tile_first(tile_first),
    .tile_last(tile_last), .tile_end(tile_end), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .tile_done(tile_done), .overflow_err(overflow_err),
    .protocol_err(protocol_err), .dbg_state(dbg_state)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [PSUM_W-1:0] rows [MAXR][COLS];
  int mbuf [DEPTH][COLS];
  bit mdef [DEPTH];
  int ready_mode = 0;
  int t0_cyc = 0;
  int rise_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  initial begin
    logic         prev_valid, holding;
    logic [W-1:0] held;
    prev_valid = 1'b0;
    holding    = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_valid) rise_cyc = cyc;
      if (holding && out_valid) check("hold_stable", out_data, held);
      holding = out_valid && !out_ready;
      held    = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_row actual=%h expected=none", out_data);
        end else begin
          check("row", out_data, exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // driver: one tile with skewed columns; model pushes expected rows up front
  task automatic run_tile(input bit first, input bit last, input bit sgn, input int n,
                          input bit gaps, input int room, input bit dup_start, input bit abort);
    int vcyc [MAXR];
    int lastc, pushed, e, s;
    logic [W-1:0] rowv;
    logic [PSUM_W-1:0] val;
    logic [COLS*PSUM_W-1:0] bus;
    bit v0, seen;
    pushed = 0;
    if (!abort) begin
      for (int r = 0; r < n && r < DEPTH; r++) begin
        rowv = '0;
        for (int j = 0; j < COLS; j++) begin
          e = int'(rows[r][j]);
          if (sgn && rows[r][j][PSUM_W-1]) e = e - (1 << PSUM_W);
          s = e + (first ? 0 : mbuf[r][j]);
          rowv[j*ACC_W +: ACC_W] = s[ACC_W-1:0];
          if (!last) mbuf[r][j] = int'(s[ACC_W-1:0]);
        end
        if (!last) mdef[r] = 1'b1;
        else if (pushed < room) begin
          exp_q.push_back(rowv);
          pushed++;
        end
      end
    end
    lastc = 0;
    for (int r = 0; r < n; r++) begin
      vcyc[r] = lastc;
      lastc += 1 + (gaps ? int'($urandom_range(0, 2)) : 0);
    end
    lastc = vcyc[n-1];
    tick();
    tile_start = 1'b1; tile_first = first; tile_last = last; is_signed = sgn;
    col0_valid = 1'b0; tile_end = 1'b0;
    for (int c = 0; c <= lastc + COLS - 1; c++) begin
      tick();
      tile_start = dup_start && (c == 1);
      tile_first = 1'($urandom());
      tile_last  = 1'($urandom());
      is_signed  = 1'($urandom());
      tile_end   = (c == lastc + 1);
      v0 = 1'b0;
      for (int j = 0; j < COLS; j++) begin
        val = PSUM_W'($urandom());
        for (int r = 0; r < n; r++) begin
          if (vcyc[r] + j == c) begin
            val = rows[r][j];
            if (j == 0) v0 = 1'b1;
          end
        end
        bus[j*PSUM_W +: PSUM_W] = val;
      end
      col_psum   = bus;
      col0_valid = v0;
      if (c == 0) t0_cyc = cyc;
    end
    tick();
    tile_start = 1'b0; tile_end = 1'b0; col0_valid = 1'b0;
    if (abort) begin
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy_before", busy, 1);
      check("abort_state_drain", dbg_state, sa_pkg::DRAIN);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_ovf", overflow_err, 0);
      check("abort_prot", protocol_err, 0);
      check("abort_tile_done", tile_done, 0);
      for (int r = 0; r < DEPTH; r++) mdef[r] = 1'b0;
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (tile_done) seen = 1'b1;
      end
      check("tile_done_seen", seen, 1);
      check("busy_after_done", busy, 0);
    end
  endtask

  task automatic wait_drain();
    int i;
    ready_mode = 0;
    i = 0;
    while ((exp_q.size() != 0 || out_valid) && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_fifo_empty", out_valid, 0);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < DEPTH; r++) mdef[r] = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill_const(input int n, input int v);
    for (int r = 0; r < n; r++)
      for (int j = 0; j < COLS; j++) rows[r][j] = PSUM_W'(v);
  endtask

  task automatic fill_rand(input int n);
    for (int r = 0; r < n; r++)
      for (int j = 0; j < COLS; j++) rows[r][j] = PSUM_W'($urandom());
  endtask

  task automatic random_tile();
    bit first, last, sgn, gaps;
    int n;
    last  = 1'($urandom_range(0, 1));
    n     = last ? int'($urandom_range(1, FIFO_DEPTH)) : int'($urandom_range(1, DEPTH));
    first = 1'($urandom_range(0, 1));
    sgn   = 1'($urandom_range(0, 1));
    gaps  = 1'($urandom_range(0, 1));
    for (int r = 0; r < n; r++) if (!mdef[r]) first = 1'b1;
    fill_rand(n);
    ready_mode = 1;
    run_tile(first, last, sgn, n, gaps, 99, 1'b0, 1'b0);
    wait_drain();
  endtask

  initial begin
    reset = 1'b1;
    col_psum = '0; col0_valid = 1'b0; is_signed = 1'b0; tile_start = 1'b0;
    tile_first = 1'b0; tile_last = 1'b0; tile_end = 1'b0;
    for (int r = 0; r < DEPTH; r++) mdef[r] = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_tile_done", tile_done, 0);
    check("reset_ovf", overflow_err, 0);
    check("reset_prot", protocol_err, 0);
    check("reset_out_data", out_data, 0);
    tick();
    reset = 1'b0;

    // single row, columns 1..4
    for (int j = 0; j < COLS; j++) rows[0][j] = PSUM_W'(j + 1);
    run_tile(1'b1, 1'b1, 1'b0, 1, 1'b0, 99, 1'b0, 1'b0);
    check("t1_latency", rise_cyc - t0_cyc, 5);
    wait_drain();

    // all-ones psum, signed then unsigned
    fill_const(1, 12'hFFF);
    run_tile(1'b1, 1'b1, 1'b1, 1, 1'b0, 99, 1'b0, 1'b0);
    run_tile(1'b1, 1'b1, 1'b0, 1, 1'b0, 99, 1'b0, 1'b0);
    wait_drain();

    // two K-tiles: 100 then 23
    fill_const(3, 100);
    run_tile(1'b1, 1'b0, 1'b0, 3, 1'b0, 99, 1'b0, 1'b0);
    fill_const(3, 23);
    run_tile(1'b0, 1'b1, 1'b0, 3, 1'b0, 99, 1'b0, 1'b0);
    wait_drain();

    for (int k = 0; k < 10; k++) random_tile();
    check("clean_ovf", overflow_err, 0);
    check("clean_prot", protocol_err, 0);

    // row index past DEPTH is dropped and must not wrap into row 0
    fill_rand(DEPTH + 1);
    run_tile(1'b1, 1'b0, 1'b1, DEPTH + 1, 1'b0, 99, 1'b0, 1'b0);
    check("row_ovf", overflow_err, 1);
    fill_rand(FIFO_DEPTH);
    run_tile(1'b0, 1'b1, 1'b1, FIFO_DEPTH, 1'b1, 99, 1'b0, 1'b0);
    wait_drain();

    do_reset();
    check("post_reset_ovf", overflow_err, 0);

    // FIFO overflow with consumer stalled
    ready_mode = 2;
    for (int r = 0; r < 5; r++)
      for (int j = 0; j < COLS; j++) rows[r][j] = PSUM_W'(r + 1);
    run_tile(1'b1, 1'b1, 1'b0, 5, 1'b0, FIFO_DEPTH, 1'b0, 1'b0);
    check("fifo_ovf", overflow_err, 1);
    check("fifo_full_valid", out_valid, 1);
    wait_drain();

    // tile_start while busy
    do_reset();
    check("pre_prot", protocol_err, 0);
    fill_rand(3);
    run_tile(1'b1, 1'b1, 1'b1, 3, 1'b1, 99, 1'b1, 1'b0);
    check("dup_start_prot", protocol_err, 1);
    wait_drain();

    // reset during DRAIN, then a clean tile
    ready_mode = 2;
    fill_rand(2);
    run_tile(1'b1, 1'b1, 1'b0, 2, 1'b0, 99, 1'b0, 1'b1);
    ready_mode = 0;
    for (int j = 0; j < COLS; j++) rows[0][j] = PSUM_W'(j + 1);
    run_tile(1'b1, 1'b1, 1'b0, 1, 1'b0, 99, 1'b0, 1'b0);
    check("t6_latency", rise_cyc - t0_cyc, 5);
    wait_drain();

    for (int k = 0; k < 6; k++) random_tile();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
